// File: rtl/perceptron_update_unit.sv
// Training side of the 64-row perceptron branch predictor: clears the weight RAMs after
// reset, then applies the perceptron rule to resolved branches and writes rows back.
module perceptron_update_unit #(
    parameter int GHR_SIZE = 12,
    parameter int HOB      = 3,
    parameter int LOB      = 5,
    parameter int THETA    = 4,
    parameter int IDX_BITS = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       upd_valid,
    output logic                       upd_ready,
    input  logic [31:0]                upd_pc,
    input  logic                       upd_dir,
    input  logic                       upd_miss,
    input  logic [GHR_SIZE-1:0]        upd_ghr,
    input  logic signed [6:0]          upd_sum,
    output logic [IDX_BITS-1:0]        rd_addr,
    input  logic [HOB*GHR_SIZE-1:0]    rd_hob,
    input  logic [LOB*GHR_SIZE-1:0]    rd_lob,
    output logic                       wr_en,
    output logic [IDX_BITS-1:0]        wr_addr,
    output logic [HOB*GHR_SIZE-1:0]    wr_hob,
    output logic [LOB*GHR_SIZE-1:0]    wr_lob,
    output logic [31:0]                train_count,
    output logic [31:0]                skip_count
);

    localparam int W     = HOB + LOB;
    localparam int SUM_W = 7;
    localparam int HW    = HOB * GHR_SIZE;
    localparam int LW    = LOB * GHR_SIZE;

    localparam logic signed [W-1:0]   W_MAX    = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]   W_MIN    = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0]   W_ONE    = {{(W-1){1'b0}}, 1'b1};
    localparam logic [SUM_W:0]        THETA_V  = THETA[SUM_W:0];
    localparam logic [IDX_BITS-1:0]   LAST_IDX = {IDX_BITS{1'b1}};

    // Magnitude of the signed prediction sum; one extra bit so the most negative sum fits.
    function automatic logic [SUM_W:0] sum_mag(input logic signed [SUM_W-1:0] s);
        logic signed [SUM_W:0] e;
        e = {s[SUM_W-1], s};
        sum_mag = e[SUM_W] ? $unsigned(-e) : $unsigned(e);
    endfunction

    function automatic logic signed [W-1:0] sat_step(input logic signed [W-1:0] w,
                                                     input logic              up);
        if (up) begin
            sat_step = (w == W_MAX) ? w : w + W_ONE;
        end else begin
            sat_step = (w == W_MIN) ? w : w - W_ONE;
        end
    endfunction

    // Control state
    logic                clearing_q, clearing_d;
    logic [IDX_BITS-1:0] clear_idx_q, clear_idx_d;
    logic                vld_p1_q, vld_p2_q, vld_p3_q;
    logic [31:0]         train_count_q, train_count_d;
    logic [31:0]         skip_count_q, skip_count_d;

    // Datapath state
    logic [IDX_BITS-1:0] idx_p1_q;
    logic                dir_p1_q, miss_p1_q;
    logic [GHR_SIZE-1:0] ghr_p1_q;
    logic signed [SUM_W-1:0] sum_p1_q;
    logic [IDX_BITS-1:0] waddr_p2_q, waddr_p3_q;
    logic [HW-1:0]       whob_p2_q, whob_p3_q;
    logic [LW-1:0]       wlob_p2_q, wlob_p3_q;

    logic                accept;
    logic                train_p1, skip_p1;
    logic [HW-1:0]       fwd_hob, new_hob;
    logic [LW-1:0]       fwd_lob, new_lob;
    logic                unused_pc;

    assign unused_pc = ^{upd_pc[31:IDX_BITS+2], upd_pc[1:0]};

    // Stage 0: request the row and accept the update
    assign rd_addr   = upd_pc[IDX_BITS+1:2];
    assign upd_ready = ~clearing_q & ~reset;
    assign accept    = upd_valid & upd_ready;

    always_comb begin
        clearing_d  = clearing_q;
        clear_idx_d = clear_idx_q;
        if (clearing_q) begin
            clear_idx_d = clear_idx_q + 1'b1;
            if (clear_idx_q == LAST_IDX) begin
                clearing_d = 1'b0;
            end
        end
        train_count_d = train_count_q + {31'd0, train_p1};
        skip_count_d  = skip_count_q + {31'd0, skip_p1};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clearing_q    <= 1'b1;
            clear_idx_q   <= '0;
            vld_p1_q      <= 1'b0;
            vld_p2_q      <= 1'b0;
            vld_p3_q      <= 1'b0;
            train_count_q <= '0;
            skip_count_q  <= '0;
        end else begin
            clearing_q    <= clearing_d;
            clear_idx_q   <= clear_idx_d;
            vld_p1_q      <= accept;
            vld_p2_q      <= train_p1;
            vld_p3_q      <= vld_p2_q;
            train_count_q <= train_count_d;
            skip_count_q  <= skip_count_d;
        end
    end

    always_ff @(posedge clk) begin
        idx_p1_q  <= rd_addr;
        dir_p1_q  <= upd_dir;
        miss_p1_q <= upd_miss;
        ghr_p1_q  <= upd_ghr;
        sum_p1_q  <= upd_sum;
    end

    // Stage 1: forward in-flight writes over stale RAM data, then train the row
    assign train_p1 = vld_p1_q & (miss_p1_q | (sum_mag(sum_p1_q) <= THETA_V));
    assign skip_p1  = vld_p1_q & ~train_p1;

    always_comb begin
        fwd_hob = rd_hob;
        fwd_lob = rd_lob;
        if (vld_p2_q && (waddr_p2_q == idx_p1_q)) begin
            fwd_hob = whob_p2_q;
            fwd_lob = wlob_p2_q;
        end else if (vld_p3_q && (waddr_p3_q == idx_p1_q)) begin
            fwd_hob = whob_p3_q;
            fwd_lob = wlob_p3_q;
        end
    end

    always_comb begin
        logic signed [W-1:0] w_old;
        logic signed [W-1:0] w_new;
        w_old   = '0;
        w_new   = '0;
        new_hob = '0;
        new_lob = '0;
        for (int i = 0; i < GHR_SIZE; i++) begin
            w_old = {fwd_hob[HOB*i +: HOB], fwd_lob[LOB*i +: LOB]};
            w_new = sat_step(w_old, ghr_p1_q[i] == dir_p1_q);
            new_hob[HOB*i +: HOB] = w_new[W-1:LOB];
            new_lob[LOB*i +: LOB] = w_new[LOB-1:0];
        end
    end

    // Stage 2: write stage, plus a one-cycle-old copy for distance-2 forwarding
    always_ff @(posedge clk) begin
        waddr_p2_q <= idx_p1_q;
        whob_p2_q  <= new_hob;
        wlob_p2_q  <= new_lob;
        waddr_p3_q <= waddr_p2_q;
        whob_p3_q  <= whob_p2_q;
        wlob_p3_q  <= wlob_p2_q;
    end

    // A reset arriving with a row in the write stage must not let that write reach the RAM.
    assign wr_en   = clearing_q | (vld_p2_q & ~reset);
    assign wr_addr = clearing_q ? clear_idx_q : waddr_p2_q;
    assign wr_hob  = clearing_q ? '0 : whob_p2_q;
    assign wr_lob  = clearing_q ? '0 : wlob_p2_q;

    assign train_count = train_count_q;
    assign skip_count  = skip_count_q;

endmodule

// File: tb/tb_perceptron_update_unit.sv
// Bench for perceptron_update_unit: models the weight RAMs, drives directed and random
// updates, and predicts every write from an integer-weight reference table.
module tb_perceptron_update_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    logic [31:0] upd_pc = '0;
    logic        upd_dir = 1'b0;
    logic        upd_miss = 1'b0;
    logic [11:0] upd_ghr = '0;
    logic signed [6:0] upd_sum = '0;
    logic [5:0]  rd_addr;
    logic [35:0] rd_hob;
    logic [59:0] rd_lob;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [35:0] wr_hob;
    logic [59:0] wr_lob;
    logic [31:0] train_count;
    logic [31:0] skip_count;

    perceptron_update_unit dut (
        .clk(clk), .reset(reset), .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_pc(upd_pc), .upd_dir(upd_dir), .upd_miss(upd_miss), .upd_ghr(upd_ghr),
        .upd_sum(upd_sum), .rd_addr(rd_addr), .rd_hob(rd_hob), .rd_lob(rd_lob),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_hob(wr_hob), .wr_lob(wr_lob),
        .train_count(train_count), .skip_count(skip_count)
    );

    always #5 clk = ~clk;

    // Weight RAMs: registered read returning old data on a same-cycle write.
    logic [35:0] ram_hob [64];
    logic [59:0] ram_lob [64];
    logic        pre_en = 1'b0;
    logic [5:0]  pre_idx = '0;
    logic [35:0] pre_hob = '0;
    logic [59:0] pre_lob = '0;

    always @(posedge clk) begin
        rd_hob <= ram_hob[rd_addr];
        rd_lob <= ram_lob[rd_addr];
        if (pre_en) begin
            ram_hob[pre_idx] <= pre_hob;
            ram_lob[pre_idx] <= pre_lob;
        end else if (wr_en) begin
            ram_hob[wr_addr] <= wr_hob;
            ram_lob[wr_addr] <= wr_lob;
        end
    end

    typedef struct {
        int          due;
        logic [5:0]  addr;
        logic [35:0] hob;
        logic [59:0] lob;
    } wr_t;

    wr_t         wq[$];
    int          m_w [64][12];
    bit          m_clear = 1'b1;
    int          m_cidx = 0;
    int unsigned m_train = 0;
    int unsigned m_skip = 0;
    int          cyc = 0;
    int          nvec = 0;
    int          nerr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_update(input int idx, input bit dir, input bit miss,
                                input logic [11:0] ghr, input logic [6:0] sum);
        int         s;
        int         mag;
        logic [7:0] b;
        wr_t        e;
        s   = int'($signed(sum));
        mag = (s < 0) ? -s : s;
        if (miss || mag <= 4) begin
            m_train++;
            e.due  = cyc + 2;
            e.addr = 6'(idx);
            e.hob  = '0;
            e.lob  = '0;
            for (int i = 0; i < 12; i++) begin
                if (ghr[i] == dir) begin
                    if (m_w[idx][i] < 127) m_w[idx][i] = m_w[idx][i] + 1;
                end else begin
                    if (m_w[idx][i] > -128) m_w[idx][i] = m_w[idx][i] - 1;
                end
                b = 8'(m_w[idx][i]);
                e.hob[3*i +: 3] = b[7:5];
                e.lob[5*i +: 5] = b[4:0];
            end
            wq.push_back(e);
        end else begin
            m_skip++;
        end
    endtask

    task automatic step(input bit rst, input bit vld, input logic [31:0] pc, input bit dir,
                        input bit miss, input logic [11:0] ghr, input logic [6:0] sum);
        bit          exp_rdy;
        bit          exp_wen;
        logic [5:0]  exp_addr;
        logic [35:0] exp_hob;
        logic [59:0] exp_lob;
        @(negedge clk);
        reset     = rst;
        upd_valid = vld;
        upd_pc    = pc;
        upd_dir   = dir;
        upd_miss  = miss;
        upd_ghr   = ghr;
        upd_sum   = sum;
        #1;
        exp_rdy = !rst && !m_clear;
        if (rst) begin
            wq.delete();
            for (int r = 0; r < 64; r++)
                for (int i = 0; i < 12; i++) m_w[r][i] = 0;
            m_train = 0;
            m_skip  = 0;
        end
        exp_wen  = 1'b0;
        exp_addr = '0;
        exp_hob  = '0;
        exp_lob  = '0;
        if (m_clear) begin
            exp_wen  = 1'b1;
            exp_addr = 6'(m_cidx);
        end else if (wq.size() > 0 && wq[0].due == cyc) begin
            exp_wen  = 1'b1;
            exp_addr = wq[0].addr;
            exp_hob  = wq[0].hob;
            exp_lob  = wq[0].lob;
            void'(wq.pop_front());
        end
        chk("upd_ready", 64'(upd_ready), 64'(exp_rdy));
        chk("wr_en", 64'(wr_en), 64'(exp_wen));
        if (exp_wen) begin
            chk("wr_addr", 64'(wr_addr), 64'(exp_addr));
            chk("wr_hob", 64'(wr_hob), 64'(exp_hob));
            chk("wr_lob", 64'(wr_lob), 64'(exp_lob));
        end
        if (vld) chk("rd_addr", 64'(rd_addr), 64'(pc[7:2]));
        if (vld && exp_rdy) model_update(int'(pc[7:2]), dir, miss, ghr, sum);
        if (rst) begin
            m_clear = 1'b1;
            m_cidx  = 0;
        end else if (m_clear) begin
            if (m_cidx == 63) m_clear = 1'b0;
            else m_cidx++;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 12'h0, 7'h0);
    endtask

    task automatic preload(input int idx, input int val);
        logic [7:0] b;
        b       = 8'(val);
        pre_idx = 6'(idx);
        pre_hob = {12{b[7:5]}};
        pre_lob = {12{b[4:0]}};
        pre_en  = 1'b1;
        idle(1);
        pre_en  = 1'b0;
        for (int i = 0; i < 12; i++) m_w[idx][i] = val;
    endtask

    task automatic chk_counters();
        chk("train_count", 64'(train_count), 64'(m_train));
        chk("skip_count", 64'(skip_count), 64'(m_skip));
    endtask

    initial begin
        logic [31:0] pc;
        logic [6:0]  rs;

        // Power-on reset for one cycle, then the full clear sweep; an update offered
        // during the sweep must be refused.
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 12'h0, 7'h0);
        for (int k = 0; k < 64; k++)
            step(1'b0, k == 10, 32'h40, 1'b1, 1'b1, 12'hFFF, 7'h0);
        idle(3);
        chk_counters();

        // Basic training from a cleared row, skip on confident-correct, train at |sum| = THETA.
        step(1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 12'hFFF, 7'h0);
        idle(3);
        chk_counters();
        step(1'b0, 1'b1, 32'h50, 1'b1, 1'b0, 12'hABC, 7'sd20);
        idle(3);
        step(1'b0, 1'b1, 32'h54, 1'b0, 1'b0, 12'h0F0, -7'sd4);
        step(1'b0, 1'b1, 32'h58, 1'b1, 1'b0, 12'h123, 7'sd5);
        step(1'b0, 1'b1, 32'h5C, 1'b1, 1'b0, 12'h321, -7'sd64);
        idle(3);
        chk_counters();

        // Saturation at both ends.
        preload(30, 127);
        step(1'b0, 1'b1, 32'h78, 1'b1, 1'b1, 12'hFFF, 7'h0);
        preload(31, -128);
        step(1'b0, 1'b1, 32'h7C, 1'b1, 1'b1, 12'h000, 7'h0);
        idle(3);

        // Back-to-back updates exercising distance-1 and distance-2 forwarding.
        for (int k = 0; k < 3; k++)
            step(1'b0, 1'b1, 32'h14, 1'b1, 1'b1, 12'hFFF, 7'h0);
        step(1'b0, 1'b1, 32'h18, 1'b1, 1'b1, 12'hFFF, 7'h0);
        step(1'b0, 1'b1, 32'h28, 1'b1, 1'b1, 12'hFFF, 7'h0);
        step(1'b0, 1'b1, 32'h18, 1'b1, 1'b1, 12'hFFF, 7'h0);
        step(1'b0, 1'b1, 32'h14, 1'b0, 1'b1, 12'h0F0, 7'h0);
        step(1'b0, 1'b1, 32'h14, 1'b0, 0, 12'h0F0, 7'sd30);
        step(1'b0, 1'b1, 32'h14, 1'b0, 1'b1, 12'h0F0, 7'h0);
        idle(3);
        chk_counters();

        // Reset with two updates in flight: neither write may appear, sweep restarts at 0.
        step(1'b0, 1'b1, 32'hA0, 1'b1, 1'b1, 12'hFFF, 7'h0);
        step(1'b0, 1'b1, 32'hA4, 1'b1, 1'b1, 12'hFFF, 7'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 12'h0, 7'h0);
        idle(66);
        chk_counters();
        step(1'b0, 1'b1, 32'hA0, 1'b1, 1'b1, 12'hFFF, 7'h0);
        idle(3);

        // Random traffic on a few rows so forwarding and saturation interact.
        for (int k = 0; k < 400; k++) begin
            pc = ($urandom() & 32'hFFFF_FF03) | (32'($urandom_range(0, 7)) << 2);
            rs = 7'($urandom());
            if ($urandom_range(0, 1) == 1) rs = 7'($urandom_range(0, 16) - 8);
            step(1'b0, $urandom_range(0, 3) != 0, pc, 1'($urandom()),
                 $urandom_range(0, 3) == 0, 12'($urandom()), rs);
        end
        idle(4);
        chk_counters();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
